// File: rtl/pid_wr_master.sv
// Host-word framed write master: assembles addr/chan/data frames from a narrow
// host stream and issues a unicast write or an N_CHAN-wide broadcast sequence.
module pid_wr_master #(
    parameter int W_HOST    = 16,
    parameter int W_WR_ADDR = 16,
    parameter int W_WR_CHAN = 16,
    parameter int W_WR_DATA = 48,
    parameter int N_CHAN    = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 host_valid_in,
    input  logic                 host_sof_in,
    input  logic [W_HOST-1:0]    host_word_in,
    output logic                 host_ready_out,
    output logic                 wr_en,
    output logic [W_WR_ADDR-1:0] wr_addr,
    output logic [W_WR_CHAN-1:0] wr_chan,
    output logic [W_WR_DATA-1:0] wr_data,
    output logic                 busy_out,
    output logic                 frame_err_out
);

    localparam int N_WORDS = W_WR_DATA / W_HOST;
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int CNT_W   = $clog2(2 * N_CHAN);
    localparam int W_AC    = (W_WR_ADDR > W_WR_CHAN) ? W_WR_ADDR : W_WR_CHAN;
    localparam int W_EXT   = (W_HOST > W_AC) ? W_HOST : W_AC;

    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(N_WORDS - 1);
    localparam logic [CNT_W-1:0]     LAST_CNT   = CNT_W'(2 * N_CHAN - 1);
    localparam logic [W_WR_CHAN:0]   N_CHAN_EXT = (W_WR_CHAN + 1)'(N_CHAN);
    localparam logic [W_WR_CHAN-1:0] CHAN_BCAST = {W_WR_CHAN{1'b1}};

    typedef enum logic [2:0] {
        S_ADDR  = 3'd0,
        S_CHAN  = 3'd1,
        S_DATA  = 3'd2,
        S_ISSUE = 3'd3,
        S_BCAST = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [W_WR_ADDR-1:0] addr_q, addr_d;
    logic [W_WR_CHAN-1:0] chan_q, chan_d;
    logic [W_WR_DATA-1:0] data_q, data_d;
    logic                 frame_err_d, frame_err_q;

    logic                 ready_q, ready_d;
    logic                 wr_en_q, wr_en_d;
    logic [W_WR_ADDR-1:0] wr_addr_q, wr_addr_d;
    logic [W_WR_CHAN-1:0] wr_chan_q, wr_chan_d;
    logic [W_WR_DATA-1:0] wr_data_q, wr_data_d;
    logic                 busy_q, busy_d;

    logic                 accept_s;
    logic [W_EXT-1:0]     word_ext_s;

    assign accept_s   = host_valid_in & ready_q;
    // Zero-extend so narrower or wider addr/chan fields both slice cleanly.
    assign word_ext_s = W_EXT'(host_word_in);

    // State and frame-buffer registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_ADDR;
            idx_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            chan_q      <= '0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            chan_q      <= chan_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state: frame parsing, resync on sof, and broadcast sequencing.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        chan_d      = chan_q;
        data_d      = data_q;
        frame_err_d = 1'b0;
        case (state_q)
            S_ADDR: begin
                if (accept_s) begin
                    if (host_sof_in) begin
                        addr_d  = word_ext_s[W_WR_ADDR-1:0];
                        state_d = S_CHAN;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_CHAN: begin
                if (accept_s) begin
                    if (host_sof_in) begin
                        frame_err_d = 1'b1;
                        addr_d      = word_ext_s[W_WR_ADDR-1:0];
                        state_d     = S_CHAN;
                    end else begin
                        chan_d  = word_ext_s[W_WR_CHAN-1:0];
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_CHAN;
                end
            end
            S_DATA: begin
                if (accept_s) begin
                    if (host_sof_in) begin
                        frame_err_d = 1'b1;
                        addr_d      = word_ext_s[W_WR_ADDR-1:0];
                        state_d     = S_CHAN;
                    end else begin
                        data_d[int'(idx_q) * W_HOST +: W_HOST] = host_word_in;
                        if (idx_q == LAST_IDX) begin
                            if ({1'b0, chan_q} < N_CHAN_EXT) begin
                                state_d = S_ISSUE;
                            end else if (chan_q == CHAN_BCAST) begin
                                cnt_d   = '0;
                                state_d = S_BCAST;
                            end else begin
                                frame_err_d = 1'b1;
                                state_d     = S_ADDR;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_ISSUE: begin
                state_d = S_ADDR;
            end
            S_BCAST: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_ADDR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_ADDR;
            end
        endcase
    end

    // Output decode from the upcoming state so every output is a flop.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_chan_d = wr_chan_q;
        wr_data_d = wr_data_q;
        ready_d   = 1'b0;
        busy_d    = 1'b1;
        case (state_d)
            S_ADDR: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            S_CHAN, S_DATA: begin
                ready_d = 1'b1;
            end
            S_ISSUE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_d;
                wr_chan_d = chan_d;
                wr_data_d = data_d;
            end
            S_BCAST: begin
                // Even counts strobe channel cnt/2; odd counts are the gap cycle.
                if (!cnt_d[0]) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_d;
                    wr_chan_d = W_WR_CHAN'(cnt_d >> 1);
                    wr_data_d = data_d;
                end else begin
                    wr_en_d = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Registered output stage.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ready_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_chan_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_chan_q <= wr_chan_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign host_ready_out = ready_q;
    assign wr_en          = wr_en_q;
    assign wr_addr        = wr_addr_q;
    assign wr_chan        = wr_chan_q;
    assign wr_data        = wr_data_q;
    assign busy_out       = busy_q;
    assign frame_err_out  = frame_err_q;

endmodule

// File: tb/tb_pid_wr_master.sv
// Randomized bench for pid_wr_master: a frame-level reference model predicts
// per-cycle handshake/strobe behaviour and queues expected writes for a monitor.
module tb_pid_wr_master;

    localparam int N_WORDS = 3;
    localparam int N_CHAN  = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        host_valid_in;
    logic        host_sof_in;
    logic [15:0] host_word_in;
    logic        host_ready_out;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_chan;
    logic [47:0] wr_data;
    logic        busy_out;
    logic        frame_err_out;

    always #5 clk_in = ~clk_in;

    pid_wr_master #(
        .W_HOST(16), .W_WR_ADDR(16), .W_WR_CHAN(16), .W_WR_DATA(48), .N_CHAN(N_CHAN)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .host_valid_in(host_valid_in), .host_sof_in(host_sof_in), .host_word_in(host_word_in),
        .host_ready_out(host_ready_out), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_chan(wr_chan), .wr_data(wr_data), .busy_out(busy_out), .frame_err_out(frame_err_out)
    );

    typedef struct packed { logic [15:0] addr; logic [15:0] chan; logic [47:0] data; } wr_t;
    typedef struct packed { logic sof; logic [15:0] word; } item_t;

    wr_t   exp_q[$];
    item_t stim_q[$];

    // Reference model: pos = -1 waiting for addr, 0 waiting for chan, k = data word k-1 next.
    int          pos;
    logic [15:0] m_addr, m_chan;
    logic [15:0] m_data[N_WORDS];
    int          sched[$];   // future strobe cycles: channel number, or -1 for a gap cycle
    logic        exp_ready, exp_busy, exp_wr_en, exp_err;
    logic [15:0] hold_addr, hold_chan;
    logic [47:0] hold_data;
    int          last_emit;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_step(input logic rst, input logic acc, input logic sof, input logic [15:0] w);
        logic popped;
        int   c;
        popped    = 1'b0;
        exp_err   = 1'b0;
        exp_wr_en = 1'b0;
        if (rst) begin
            pos = -1;
            sched.delete();
            exp_ready = 1'b0;
            exp_busy  = 1'b0;
            hold_addr = 16'h0000;
            hold_chan = 16'h0000;
            hold_data = 48'h0;
        end else begin
            if (acc) begin
                if (sof) begin
                    if (pos >= 0) exp_err = 1'b1;
                    m_addr = w;
                    pos    = 0;
                end else if (pos < 0) begin
                    exp_err = 1'b1;
                end else if (pos == 0) begin
                    m_chan = w;
                    pos    = 1;
                end else begin
                    m_data[pos-1] = w;
                    if (pos == N_WORDS) begin
                        if (m_chan < N_CHAN) begin
                            sched.push_back(int'(m_chan));
                        end else if (m_chan == 16'hFFFF) begin
                            for (int k = 0; k < N_CHAN; k++) begin
                                sched.push_back(k);
                                sched.push_back(-1);
                            end
                        end else begin
                            exp_err = 1'b1;
                        end
                        pos = -1;
                    end else begin
                        pos++;
                    end
                end
            end
            if (sched.size() > 0) begin
                c      = sched.pop_front();
                popped = 1'b1;
                if (c >= 0) begin
                    exp_wr_en = 1'b1;
                    hold_addr = m_addr;
                    hold_chan = 16'(c);
                    hold_data = {m_data[2], m_data[1], m_data[0]};
                    exp_q.push_back('{addr: hold_addr, chan: hold_chan, data: hold_data});
                    last_emit = c;
                end
            end
            exp_ready = !popped;
            exp_busy  = popped || (pos >= 0);
        end
    endtask

    // One clock of stimulus: inputs change on the falling edge, model predicts the next cycle.
    task automatic cycle(input logic rst, input int vpct);
        logic        v, s, acc;
        logic [15:0] w;
        @(negedge clk_in);
        v   = (stim_q.size() > 0) && ($urandom_range(99) < vpct);
        s   = v ? stim_q[0].sof : 1'($urandom_range(1));
        w   = v ? stim_q[0].word : 16'($urandom);
        rst_in        = rst;
        host_valid_in = v;
        host_sof_in   = s;
        host_word_in  = w;
        acc = v && exp_ready && !rst;
        model_step(rst, acc, s, w);
        if (acc) void'(stim_q.pop_front());
    endtask

    task automatic push_word(input logic s, input logic [15:0] w);
        stim_q.push_back('{sof: s, word: w});
    endtask

    task automatic push_frame(input logic [15:0] a, input logic [15:0] ch,
                              input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
        push_word(1'b1, a);
        push_word(1'b0, ch);
        push_word(1'b0, d0);
        push_word(1'b0, d1);
        push_word(1'b0, d2);
    endtask

    task automatic drain(input int vpct, input int budget);
        int n;
        n = 0;
        while ((stim_q.size() > 0 || sched.size() > 0) && n < budget) begin
            cycle(1'b0, vpct);
            n++;
        end
        n_cmp++;
        if (stim_q.size() > 0 || sched.size() > 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d words left, budget %0d required empty", stim_q.size(), budget);
            stim_q.delete();
        end
        repeat (2) cycle(1'b0, 0);
    endtask

    task automatic random_frame();
        int          kind, nd;
        logic [15:0] ch;
        kind = $urandom_range(9);
        if (kind == 0) begin
            push_word(1'b0, 16'($urandom));
        end else if (kind == 1) begin
            nd = $urandom_range(2);
            push_word(1'b1, 16'($urandom));
            push_word(1'b0, 16'($urandom_range(7)));
            for (int i = 0; i < nd; i++) push_word(1'b0, 16'($urandom));
        end else begin
            if (kind < 7)       ch = 16'($urandom_range(N_CHAN - 1));
            else if (kind == 7) ch = 16'hFFFF;
            else                ch = 16'($urandom_range(16'hFFFE, N_CHAN));
            push_frame(16'($urandom), ch, 16'($urandom), 16'($urandom), 16'($urandom));
        end
    endtask

    // Monitor: compares every cycle; pops an expected write whenever the DUT strobes.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk_in);
            #1;
            chk("ready", 64'(host_ready_out), 64'(exp_ready));
            chk("busy", 64'(busy_out), 64'(exp_busy));
            chk("wr_en", 64'(wr_en), 64'(exp_wr_en));
            chk("frame_err", 64'(frame_err_out), 64'(exp_err));
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e.addr));
                    chk("wr_chan", 64'(wr_chan), 64'(e.chan));
                    chk("wr_data", 64'(wr_data), 64'(e.data));
                end
            end else begin
                chk("hold_addr", 64'(wr_addr), 64'(hold_addr));
                chk("hold_chan", 64'(wr_chan), 64'(hold_chan));
                chk("hold_data", 64'(wr_data), 64'(hold_data));
            end
        end
    end

    initial begin
        int n;
        rst_in = 1'b1; host_valid_in = 1'b0; host_sof_in = 1'b0; host_word_in = 16'h0000;
        pos = -1; m_addr = 16'h0; m_chan = 16'h0; last_emit = -1;
        for (int i = 0; i < N_WORDS; i++) m_data[i] = 16'h0;
        model_step(1'b1, 1'b0, 1'b0, 16'h0);
        repeat (2) cycle(1'b1, 0);

        // Unicast, broadcast, sof-resync, stray word and out-of-range channel.
        push_frame(16'h0002, 16'h0003, 16'h1111, 16'h2222, 16'h3333);
        drain(100, 40);
        push_frame(16'h00A5, 16'hFFFF, 16'hAAAA, 16'hBBBB, 16'hCCCC);
        drain(100, 60);
        push_word(1'b1, 16'h0010); push_word(1'b0, 16'h0001);
        push_word(1'b0, 16'hDEAD); push_word(1'b1, 16'h0020);
        push_word(1'b0, 16'h0005); push_word(1'b0, 16'h4444);
        push_word(1'b0, 16'h5555); push_word(1'b0, 16'h6666);
        drain(100, 40);
        push_word(1'b0, 16'h1234);
        push_frame(16'h0030, 16'h0008, 16'h7777, 16'h8888, 16'h9999);
        drain(100, 40);
        push_frame(16'h0000, 16'h0007, 16'hFFFF, 16'h0000, 16'hFFFF);
        drain(100, 40);

        // Valid held high across several frames, including a broadcast.
        for (int i = 0; i < 6; i++) random_frame();
        push_frame(16'h0BCA, 16'hFFFF, 16'h0102, 16'h0304, 16'h0506);
        for (int i = 0; i < 6; i++) random_frame();
        drain(100, 400);

        // Random traffic with random valid gaps.
        for (int i = 0; i < 50; i++) random_frame();
        drain(60, 3000);

        // Reset while the third broadcast write is on the bus.
        push_frame(16'h0C0C, 16'hFFFF, 16'h1357, 16'h2468, 16'h9BDF);
        last_emit = -1;
        n = 0;
        while (!(exp_wr_en && last_emit == 2) && n < 60) begin
            cycle(1'b0, 100);
            n++;
        end
        chk("bcast_third_reached", 64'(last_emit), 64'(2));
        cycle(1'b1, 0);
        stim_q.delete();
        repeat (20) cycle(1'b0, 0);

        push_frame(16'h0E0E, 16'h0001, 16'hCAFE, 16'hBEEF, 16'hF00D);
        drain(70, 100);
        repeat (3) cycle(1'b0, 0);

        chk("expected_writes_left", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
